// File: rtl/bsg_event_window_ctrl.sv
// Sequences a shared clear/up event counter to measure events over a programmable
// window, returning a saturating count and overflow flag on a valid/yumi interface.
module bsg_event_window_ctrl #(
    parameter int max_val_p      = 63,
    parameter int window_width_p = 16,
    localparam int count_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_v_i,
    input  logic [window_width_p-1:0] window_len_i,
    output logic                      start_ready_o,
    input  logic                      abort_i,
    input  logic                      event_i,
    output logic                      ctr_clear_o,
    output logic                      ctr_up_o,
    input  logic [count_width_lp-1:0] ctr_count_i,
    output logic                      result_v_o,
    output logic [count_width_lp-1:0] result_count_o,
    output logic                      result_sat_o,
    input  logic                      result_yumi_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SAMPLE = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [count_width_lp-1:0] max_count_lp = count_width_lp'(max_val_p);

    state_e                      state_r, state_n;
    logic [window_width_p-1:0]   len_r;
    logic [window_width_p-1:0]   remaining_r;
    logic                        sat_r;
    logic [count_width_lp-1:0]   result_count_r;
    logic                        result_sat_r;
    logic                        at_max;
    logic                        abort_active;

    assign at_max       = (ctr_count_i >= max_count_lp);
    assign abort_active = abort_i && (state_r != IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n       = state_r;
        start_ready_o = 1'b0;
        ctr_clear_o   = 1'b0;
        ctr_up_o      = 1'b0;
        result_v_o    = 1'b0;
        case (state_r)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_v_i) begin
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                ctr_clear_o = ~abort_i;
                state_n     = (len_r != '0) ? SAMPLE : DRAIN;
            end
            SAMPLE: begin
                // Holding up at max keeps the counter from wrapping back to zero.
                ctr_up_o = event_i & ~at_max & ~abort_i;
                if (remaining_r == window_width_p'(1)) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                state_n = DONE;
            end
            DONE: begin
                result_v_o = 1'b1;
                if (result_yumi_i) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort_active) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            len_r          <= '0;
            remaining_r    <= '0;
            sat_r          <= 1'b0;
            result_count_r <= '0;
            result_sat_r   <= 1'b0;
        end else if (!abort_active) begin
            case (state_r)
                IDLE: begin
                    if (start_v_i) begin
                        len_r <= window_len_i;
                        sat_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    remaining_r <= len_r;
                end
                SAMPLE: begin
                    remaining_r <= remaining_r - window_width_p'(1);
                    if (event_i && at_max) begin
                        sat_r <= 1'b1;
                    end
                end
                // The final up of the window is only visible in the counter one cycle later.
                DRAIN: begin
                    result_count_r <= ctr_count_i;
                    result_sat_r   <= sat_r;
                end
                default: begin
                end
            endcase
        end
    end

    assign result_count_o = result_count_r;
    assign result_sat_o   = result_sat_r;

endmodule

// File: tb/tb_bsg_event_window_ctrl.sv
// Directed bench for bsg_event_window_ctrl with a behavioural clear/up counter
// (max 63, never both clear and up) attached to the controller's counter port.
module tb_bsg_event_window_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start_v;
    logic [15:0] window_len;
    logic        start_ready;
    logic        abort;
    logic        event_in;
    logic        ctr_clear;
    logic        ctr_up;
    logic [5:0]  ctr_count;
    logic        result_v;
    logic [5:0]  result_count;
    logic        result_sat;
    logic        result_yumi;

    int checks = 0;
    int errors = 0;

    bsg_event_window_ctrl #(
        .max_val_p      (63),
        .window_width_p (16)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .start_v_i      (start_v),
        .window_len_i   (window_len),
        .start_ready_o  (start_ready),
        .abort_i        (abort),
        .event_i        (event_in),
        .ctr_clear_o    (ctr_clear),
        .ctr_up_o       (ctr_up),
        .ctr_count_i    (ctr_count),
        .result_v_o     (result_v),
        .result_count_o (result_count),
        .result_sat_o   (result_sat),
        .result_yumi_i  (result_yumi)
    );

    // Counter model: plain 6-bit register, so any missed saturation would wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr_count <= '0;
        end else if (ctr_clear) begin
            ctr_count <= ctr_up ? 6'd1 : 6'd0;
        end else if (ctr_up) begin
            ctr_count <= ctr_count + 6'd1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: no events, 1: event every SAMPLE cycle, 2: events on sample cycles 1,3,5,7
    task automatic measure(input int len, input int mode, input int exp_count,
                           input int exp_sat, input int exp_ups);
        int ups;
        int clears;
        int overlap;
        check_output("ready_before_start", start_ready, 1);
        start_v    = 1'b1;
        window_len = len[15:0];
        tick();
        start_v    = 1'b0;
        window_len = 16'hFFFF;
        #1;
        check_output("clear_cycle1", ctr_clear, 1);
        check_output("no_up_cycle1", ctr_up, 0);
        check_output("busy_not_ready", start_ready, 0);
        tick();
        ups = 0;
        clears = 0;
        overlap = 0;
        for (int i = 0; i < len; i++) begin
            event_in = (mode == 1) || (mode == 2 && (i % 2) == 1 && i < 8);
            #1;
            ups    += int'(ctr_up);
            clears += int'(ctr_clear);
            if (ctr_up && ctr_clear) overlap++;
            tick();
        end
        event_in = 1'b1;
        #1;
        check_output("drain_no_up", ctr_up, 0);
        check_output("drain_no_clear", ctr_clear, 0);
        check_output("drain_no_valid", result_v, 0);
        tick();
        event_in = 1'b0;
        #1;
        check_output("done_valid", result_v, 1);
        check_output("result_count", result_count, exp_count);
        check_output("result_sat", result_sat, exp_sat);
        check_output("up_pulses", ups, exp_ups);
        check_output("clears_in_sample", clears, 0);
        check_output("clear_up_overlap", overlap, 0);
        check_output("counter_value", ctr_count, exp_count);
    endtask

    task automatic take_result();
        result_yumi = 1'b1;
        tick();
        result_yumi = 1'b0;
        #1;
        check_output("idle_after_yumi", start_ready, 1);
        check_output("valid_after_yumi", result_v, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start_v     = 1'b0;
        window_len  = '0;
        abort       = 1'b0;
        event_in    = 1'b0;
        result_yumi = 1'b0;
        #3;
        check_output("rst_ready", start_ready, 1);
        check_output("rst_clear", ctr_clear, 0);
        check_output("rst_up", ctr_up, 0);
        check_output("rst_valid", result_v, 0);
        check_output("rst_sat", result_sat, 0);
        check_output("rst_count", result_count, 0);
        #9 reset_n = 1'b1;
        tick();

        // L=10 with four sparse events
        measure(10, 2, 4, 0, 4);
        take_result();

        // L=100 with continuous events saturates at 63
        measure(100, 1, 63, 1, 63);
        take_result();

        // L=0 goes straight from CLEAR to DRAIN
        measure(0, 1, 0, 0, 0);
        take_result();

        // exactly max events is not saturation; one more is
        measure(63, 1, 63, 0, 63);
        take_result();
        measure(64, 1, 63, 1, 63);
        take_result();

        // abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check_output("abort_idle_ready", start_ready, 1);

        // abort in the 5th SAMPLE cycle of L=20
        start_v    = 1'b1;
        window_len = 16'd20;
        tick();
        start_v = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            event_in = 1'b1;
            tick();
        end
        abort = 1'b1;
        #1;
        check_output("abort_cycle_no_up", ctr_up, 0);
        tick();
        abort    = 1'b0;
        event_in = 1'b0;
        #1;
        check_output("abort_to_idle", start_ready, 1);
        check_output("abort_no_valid", result_v, 0);
        for (int i = 0; i < 3; i++) tick();
        #1;
        check_output("abort_still_no_valid", result_v, 0);
        measure(3, 1, 3, 0, 3);
        take_result();

        // abort in DONE drops the result
        measure(2, 1, 2, 0, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check_output("abort_done_ready", start_ready, 1);
        check_output("abort_done_valid", result_v, 0);

        // asynchronous reset in the middle of SAMPLE
        start_v    = 1'b1;
        window_len = 16'd10;
        tick();
        start_v  = 1'b0;
        tick();
        event_in = 1'b1;
        tick();
        tick();
        #1;
        check_output("pre_reset_up", ctr_up, 1);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_rst_ready", start_ready, 1);
        check_output("async_rst_up", ctr_up, 0);
        check_output("async_rst_valid", result_v, 0);
        check_output("async_rst_count", result_count, 0);
        #2 reset_n = 1'b1;
        event_in = 1'b0;
        tick();

        // result held while the consumer stalls
        measure(2, 1, 2, 0, 2);
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            check_output("stall_valid", result_v, 1);
            check_output("stall_count", result_count, 2);
            check_output("stall_sat", result_sat, 0);
            check_output("stall_not_ready", start_ready, 0);
        end
        take_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
